bitmanip_ctrl: RTL and testbench

BITMANIP_CTRL -- requirements
Module: bitmanip_ctrl

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/bitcounter.sv | 17 +
 rtl/bmc_stage.sv | 31 +++
 rtl/zeroscounter.sv | 41 ++++
 rtl/bitmanip_ctrl.sv | 120 ++++++++++++
 tb/tb_bitmanip_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_pkg.sv
// Shared opcode encoding and datapath constants for the bit-manipulation unit.
// Operand preconditioning lets every count run in 64-bit mode.
package riscv_pkg;

  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    BOP_CPOP  = 3'b000,
    BOP_CLZ   = 3'b001,
    BOP_CTZ   = 3'b010,
    BOP_CPOPW = 3'b100,
    BOP_CLZW  = 3'b101,
    BOP_CTZW  = 3'b110
  } bop_t;

  function automatic logic bop_legal(input logic [2:0] op);
    logic ok;
    case (op)
      BOP_CPOP, BOP_CLZ, BOP_CTZ, BOP_CPOPW, BOP_CLZW, BOP_CTZW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // W forms pad the unused half so that a 64-bit count gives the 32-bit answer.
  function automatic logic [63:0] precondition(input logic [2:0] op, input logic [63:0] a);
    logic [63:0] r;
    case (op)
      BOP_CPOPW: r = {32'h0, a[31:0]};
      BOP_CTZW:  r = {32'hFFFF_FFFF, a[31:0]};
      BOP_CLZW:  r = {a[31:0], 32'hFFFF_FFFF};
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitcounter.sv
// Population count of a 64-bit operand (optionally only the low word).
module bitcounter (
  input  logic        is_32_bit_mode,
  input  logic [63:0] operand,
  output logic [6:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i < 32) || !is_32_bit_mode) begin
        count = count + {6'b0, operand[i]};
      end
    end
  end

endmodule

// File: rtl/bmc_stage.sv
// One valid/ready register slice: holds its payload until the downstream advances.
module bmc_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        out_valid <= in_valid;
      end
      if (adv && in_valid && !flush) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/zeroscounter.sv
// Leading (oper_type=1) or trailing (oper_type=0) zero count of a 64-bit operand.
module zeroscounter (
  input  logic        is_32_bit_mode,
  input  logic        oper_type,
  input  logic [63:0] operand,
  output logic [6:0]  count
);

  logic [63:0] padded;
  logic [63:0] scan;
  logic        hit;

  always_comb begin
    if (is_32_bit_mode) begin
      padded = oper_type ? {operand[31:0], 32'hFFFF_FFFF} : {32'hFFFF_FFFF, operand[31:0]};
    end else begin
      padded = operand;
    end
  end

  // Leading zeros are counted as trailing zeros of the bit-reversed word.
  always_comb begin
    scan = '0;
    for (int i = 0; i < 64; i++) begin
      scan[i] = oper_type ? padded[63-i] : padded[i];
    end
  end

  always_comb begin
    count = '0;
    hit   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (scan[i]) begin
        hit = 1'b1;
      end else if (!hit) begin
        count = count + 7'd1;
      end
    end
  end

endmodule

// File: rtl/bitmanip_ctrl.sv
// Two-stage CPOP/CLZ/CTZ (and W forms) unit with valid/ready handshakes, flush
// and a completed-response counter.
module bitmanip_ctrl #(
  parameter int WIDTH = riscv_pkg::WIDTH,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             busy,
  output logic [31:0]      op_count
);

  import riscv_pkg::*;

  localparam int S1_W = 3 + TAG_W + WIDTH;
  localparam int S2_W = 1 + TAG_W + CNT_W;

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  logic             accept;
  logic [S1_W-1:0]  s1_in, s1_data;
  logic [S2_W-1:0]  s2_in, s2_data;

  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH-1:0] s1_a;

  logic [CNT_W-1:0] cpop_cnt, zc_cnt, s1_res;
  logic             s1_err, clz_sel;

  logic [CNT_W-1:0] s2_res;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_err;

  assign s2_adv    = !s2_valid || resp_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign req_ready = s1_adv && !flush;
  assign accept    = req_valid && req_ready;

  assign s1_in = {req_op, req_tag, precondition(req_op, req_a)};

  bmc_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .adv       (s1_adv),
    .in_valid  (accept),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_data  (s1_data)
  );

  assign {s1_op, s1_tag, s1_a} = s1_data;
  assign clz_sel = (s1_op[1:0] == 2'b01);

  bitcounter u_cpop (
    .is_32_bit_mode (1'b0),
    .operand        (s1_a),
    .count          (cpop_cnt)
  );

  zeroscounter u_zc (
    .is_32_bit_mode (1'b0),
    .oper_type      (clz_sel),
    .operand        (s1_a),
    .count          (zc_cnt)
  );

  always_comb begin
    s1_res = '0;
    s1_err = 1'b0;
    case (s1_op)
      BOP_CPOP, BOP_CPOPW:                     s1_res = cpop_cnt;
      BOP_CLZ, BOP_CLZW, BOP_CTZ, BOP_CTZW:    s1_res = zc_cnt;
      default:                                 s1_err = !bop_legal(s1_op);
    endcase
  end

  assign s2_in = {s1_err, s1_tag, s1_res};

  bmc_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .adv       (s2_adv),
    .in_valid  (s1_valid),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_data  (s2_data)
  );

  assign {s2_err, s2_tag, s2_res} = s2_data;

  // Outputs read as zero whenever no result is present, so flushed leftovers never show.
  assign resp_valid = s2_valid;
  assign resp_data  = s2_valid ? {{(WIDTH-CNT_W){1'b0}}, s2_res} : '0;
  assign resp_tag   = s2_valid ? s2_tag : '0;
  assign resp_err   = s2_valid && s2_err;
  assign busy       = s1_valid || s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (resp_valid && resp_ready) begin
      op_count <= op_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_bitmanip_ctrl.sv
// Self-checking bench for bitmanip_ctrl: directed scenarios plus randomized traffic
// scored against a queue-based reference model.
module tb_bitmanip_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, flush;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [2:0]  req_op;
  logic [63:0] req_a, resp_data;
  logic [4:0]  req_tag, resp_tag;
  logic [31:0] op_count;

  always #5 clk = ~clk;

  bitmanip_ctrl #(.WIDTH(64), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_tag    (req_tag),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          model_count = 0;
  logic        popped;
  logic [4:0]  popped_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a);
    int n;
    n = 0;
    case (op)
      3'b000: n = $countones(a);
      3'b100: n = $countones(a[31:0]);
      3'b001: begin n = 64; for (int i = 0; i < 64; i++) if (a[i]) n = 63 - i; end
      3'b101: begin n = 32; for (int i = 0; i < 32; i++) if (a[i]) n = 31 - i; end
      3'b010: begin n = 64; for (int i = 63; i >= 0; i--) if (a[i]) n = i; end
      3'b110: begin n = 32; for (int i = 31; i >= 0; i--) if (a[i]) n = i; end
      default: n = 0;
    endcase
    return 64'(n);
  endfunction

  function automatic logic ref_err(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b111);
  endfunction

  function automatic logic [63:0] rand_a();
    logic [63:0] one;
    one = 64'd1;
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'h0;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return one << $urandom_range(0, 63);
      4: return {$urandom, 32'h0};
      default: return {32'h0, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    req_op     = 3'b000;
    req_a      = 64'h0;
    req_tag    = 5'd0;
  endtask

  // Called once per cycle after inputs settle: scores this cycle's handshakes.
  task automatic observe(input string pfx);
    exp_t e;
    popped = 1'b0;
    if (resp_valid && resp_ready) begin
      model_count++;
      if (q.size() == 0) begin
        check({pfx, "_unexpected_resp"}, 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check({pfx, "_data"}, resp_data, e.data);
        check({pfx, "_tag"}, 64'(resp_tag), 64'(e.tag));
        check({pfx, "_err"}, 64'(resp_err), 64'(e.err));
        popped     = 1'b1;
        popped_tag = resp_tag;
      end
    end
    if (flush) q.delete();
    if (req_valid && req_ready) begin
      q.push_back('{data: ref_err(req_op) ? 64'h0 : ref_result(req_op, req_a),
                    tag: req_tag, err: ref_err(req_op)});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    model_count = 0;
  endtask

  logic [2:0]  vop[6]  = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b110, 3'b101};
  logic [63:0] va[6]   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1,
                           64'hFFFF_FFFF_0000_0003, 64'hFFFF_FFFF_0000_0000,
                           64'h0000_0000_8000_0000};
  logic [63:0] vexp[6] = '{64'd64, 64'd64, 64'd63, 64'd2, 64'd32, 64'd0};
  logic [2:0]  legal_ops[6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

  initial begin
    int          acc, ndone, cnt0;
    logic        seen, hold, prev_flush;
    logic [63:0] cap_data;
    logic [4:0]  cap_tag;
    logic        cap_err;
    logic [4:0]  got_tags[$];

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // Directed values, two-cycle latency
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_op = vop[i]; req_a = va[i]; req_tag = 5'(i + 1);
      #1;
      check("val_ready", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      check("val_lat_n1", 64'(resp_valid), 64'd0);
      tick();
      check("val_lat_n2", 64'(resp_valid), 64'd1);
      check("val_data", resp_data, vexp[i]);
      check("val_tag", 64'(resp_tag), 64'(i + 1));
      check("val_err", 64'(resp_err), 64'd0);
      tick();
    end
    check("val_op_count", 64'(op_count), 64'd6);

    // Reset with a CPOP in flight
    req_valid = 1'b1; req_op = 3'b000; req_a = 64'hFFFF_FFFF_FFFF_FFFF; req_tag = 5'd9;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rstfl_resp_valid", 64'(resp_valid), 64'd0);
    check("rstfl_op_count", 64'(op_count), 64'd0);
    check("rstfl_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    q.delete();
    model_count = 0;
    tick();
    check("rstfl_req_ready", 64'(req_ready), 64'd1);

    // Back-to-back tags 0..9
    ndone = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) begin
        req_valid = 1'b1; req_tag = 5'(c);
        req_op = legal_ops[$urandom_range(0, 5)]; req_a = rand_a();
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (c < 10) check("b2b_ready", 64'(req_ready), 64'd1);
      observe("b2b");
      if (popped) begin
        check("b2b_cycle", 64'(c), 64'(ndone + 2));
        check("b2b_order", 64'(popped_tag), 64'(ndone));
        ndone++;
      end
      tick();
    end
    check("b2b_count", 64'(ndone), 64'd10);
    check("b2b_op_count", 64'(op_count), 64'd10);

    // Backpressure
    resp_ready = 1'b0;
    acc = 0;
    cap_data = '0; cap_tag = '0; cap_err = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_tag = 5'(c); req_op = 3'b000; req_a = rand_a();
      #1;
      if (c == 2) begin
        cap_data = resp_data; cap_tag = resp_tag; cap_err = resp_err;
      end
      if (c > 2) begin
        check("bp_hold_valid", 64'(resp_valid), 64'd1);
        check("bp_hold_data", resp_data, cap_data);
        check("bp_hold_tag", 64'(resp_tag), 64'(cap_tag));
        check("bp_hold_err", 64'(resp_err), 64'(cap_err));
      end
      if (req_valid && req_ready) acc++;
      observe("bp");
      tick();
    end
    req_valid = 1'b0;
    #1;
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    resp_ready = 1'b1;
    got_tags.delete();
    for (int c = 0; c < 6; c++) begin
      #1;
      observe("bp_rel");
      if (popped) got_tags.push_back(popped_tag);
      tick();
    end
    check("bp_rel_count", 64'(got_tags.size()), 64'd2);
    if (got_tags.size() == 2) begin
      check("bp_rel_tag0", 64'(got_tags[0]), 64'd0);
      check("bp_rel_tag1", 64'(got_tags[1]), 64'd1);
    end

    // Illegal opcode
    cnt0 = 12;
    check("ill_op_count_before", 64'(op_count), 64'(cnt0));
    req_valid = 1'b1; req_op = 3'b111; req_tag = 5'd7; req_a = 64'hDEAD_BEEF_1234_5678;
    #1;
    observe("ill");
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        check("ill_err", 64'(resp_err), 64'd1);
        check("ill_data", resp_data, 64'd0);
        check("ill_tag", 64'(resp_tag), 64'd7);
      end
      observe("ill");
      tick();
    end
    check("ill_seen", 64'(seen), 64'd1);
    check("ill_op_count", 64'(op_count), 64'(cnt0 + 1));

    // Flush with two operations in flight
    resp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = 1'b1; req_tag = 5'(20 + c); req_op = 3'b001; req_a = rand_a();
      #1;
      observe("fl");
      tick();
    end
    req_valid = 1'b1; req_tag = 5'd30; flush = 1'b1;
    #1;
    check("fl_ready_low", 64'(req_ready), 64'd0);
    observe("fl");
    tick();
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    check("fl_resp_valid", 64'(resp_valid), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    req_valid = 1'b1; req_op = 3'b010; req_a = 64'h10; req_tag = 5'd3;
    observe("fl");
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        check("fl_ctz_data", resp_data, 64'd4);
        check("fl_ctz_tag", 64'(resp_tag), 64'd3);
      end
      observe("fl");
      tick();
    end
    check("fl_ctz_seen", 64'(seen), 64'd1);

    // Randomized traffic against the model
    idle_inputs();
    do_reset();
    hold = 1'b0; prev_flush = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_op     = 3'($urandom_range(0, 7));
      req_a      = rand_a();
      req_tag    = 5'($urandom_range(0, 31));
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      #1;
      if (hold && !prev_flush) begin
        check("rnd_hold_valid", 64'(resp_valid), 64'd1);
        check("rnd_hold_data", resp_data, cap_data);
        check("rnd_hold_tag", 64'(resp_tag), 64'(cap_tag));
        check("rnd_hold_err", 64'(resp_err), 64'(cap_err));
      end
      check("rnd_busy", 64'(busy), 64'(q.size() != 0));
      check("rnd_ready", 64'(req_ready), 64'(!flush && (q.size() < 2 || resp_ready)));
      hold = resp_valid && !resp_ready;
      prev_flush = flush;
      cap_data = resp_data; cap_tag = resp_tag; cap_err = resp_err;
      observe("rnd");
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      #1;
      observe("drain");
      tick();
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    check("rnd_op_count", 64'(op_count), 64'(32'(model_count)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
